// File: rtl/image_stream_reader_pkg.sv
// Shared types for the image stream reader: default frame size, pixel and
// marker types, and the sequencer state encoding.
package img_stream_pkg;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int PIX_W_DEF      = 8;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  // Frame/line markers that travel alongside each pixel.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } stream_flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/image_stream_reader_if.sv
// Valid/ready pixel stream with frame and line markers.
interface image_stream_reader_if #(
  parameter int W = 8
) ();

  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] x_data;
  logic         x_sof;
  logic         x_eol;
  logic         x_eof;

  modport master (
    output x_valid,
    output x_data,
    output x_sof,
    output x_eol,
    output x_eof,
    input  x_ready
  );

  modport slave (
    input  x_valid,
    input  x_data,
    input  x_sof,
    input  x_eol,
    input  x_eof,
    output x_ready
  );

endinterface

// File: rtl/image_stream_reader_fifo.sv
// Small synchronous FIFO that absorbs the RAM read latency. Any depth is
// allowed; pointers wrap explicitly so non-power-of-two depths work.
module stream_fifo #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage holds data only, so it is written without reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/image_stream_reader.sv
// Streams a stored frame out of a 1-cycle-latency RAM in raster order as a
// valid/ready pixel stream with sof/eol/eof markers. Reads are throttled so
// that queued plus in-flight pixels never exceed the FIFO depth, which keeps
// x_ready out of any combinational path to the RAM.
module image_stream_reader
  import img_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int W          = 8,
  parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W-1:0]      mem_rd_data,
  image_stream_reader_if.master xs
);

  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WORD_W = $bits(stream_flags_t) + W;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  stream_flags_t       issue_flags;
  logic                rd_vld_p1;
  stream_flags_t       flags_p1;
  logic [WORD_W-1:0]   push_word_p1;
  logic [WORD_W-1:0]   head_word;
  stream_flags_t       head_flags;
  logic [W-1:0]        head_pixel;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W:0]      occupancy;
  logic                pop;
  logic                drain_done;

  // ---- p0: read issue, throttled by queued + in-flight pixels
  assign occupancy   = {1'b0, fifo_count} + (CNT_W+1)'(rd_vld_p1);
  assign mem_rd_en   = (state == ISSUE) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign issue_flags = '{sof: (row == '0) && (col == '0),
                         eol: (col == COL_LAST),
                         eof: (row == ROW_LAST) && (col == COL_LAST)};

  // The last pixel leaves on this edge and nothing else is queued or pending.
  assign drain_done = !rd_vld_p1 &&
                      (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

  // Sequencer: frame start, address/raster counters, drain and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      col       <= '0;
      row       <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      done      <= 1'b0;
      rd_vld_p1 <= mem_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            mem_addr <= '0;
            col      <= '0;
            row      <= '0;
          end
        end
        ISSUE: begin
          if (mem_rd_en) begin
            mem_addr <= mem_addr + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (issue_flags.eof) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- p1: markers follow the read through the RAM latency
  always_ff @(posedge clk) begin
    if (mem_rd_en) flags_p1 <= issue_flags;
  end

  assign push_word_p1 = {flags_p1, mem_rd_data};
  assign pop          = !fifo_empty && xs.x_ready;

  stream_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_vld_p1),
    .push_data (push_word_p1),
    .pop       (pop),
    .pop_data  (head_word),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // ---- p2: FIFO head drives the stream; outputs are zero when nothing is queued
  assign {head_flags, head_pixel} = head_word;
  assign xs.x_valid = !fifo_empty;
  assign xs.x_data  = fifo_empty ? '0 : head_pixel;
  assign xs.x_sof   = !fifo_empty && head_flags.sof;
  assign xs.x_eol   = !fifo_empty && head_flags.eol;
  assign xs.x_eof   = !fifo_empty && head_flags.eof;

  // A returning read must always find room in the FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_vld_p1 && fifo_full && !pop));

endmodule

// File: tb/tb_image_stream_reader.sv
// Directed bench for image_stream_reader on a 4x3 frame, RAM[i] = 8'h10 + i.
module tb_image_stream_reader;
  import img_stream_pkg::*;

  localparam int IW = 4;
  localparam int IH = 3;
  localparam int N  = IW * IH;
  localparam int PW = 8;
  localparam int AW = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rd_data;
  pixel_t        ram [N];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  image_stream_reader_if #(.W(PW)) xs ();

  image_stream_reader #(
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH),
    .W          (PW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .xs          (xs.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  // Stream log collected mid-cycle
  logic [10:0] cur;
  logic [10:0] beats [$];
  int          pop_cyc [$];
  int          done_cyc [$];
  int          first_valid_cyc;
  int          stall_viol, occ_viol, addr_viol;
  int          issued, popped;
  logic        prev_stall;
  logic [10:0] prev_word;

  assign cur = {xs.x_sof, xs.x_eol, xs.x_eof, xs.x_data};

  always @(negedge clk) begin
    if (!rst_n) begin
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!xs.x_valid || cur !== prev_word)) stall_viol++;
      if (mem_rd_en) begin
        if (issued - popped >= FD) occ_viol++;
        if (mem_addr !== AW'(issued % N)) addr_viol++;
        issued++;
      end
      if (xs.x_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (xs.x_valid && xs.x_ready) begin
        beats.push_back(cur);
        pop_cyc.push_back(cyc + 1);
        popped++;
      end
      if (done) done_cyc.push_back(cyc);
      prev_stall = xs.x_valid && !xs.x_ready;
      prev_word  = cur;
    end
  end

  function automatic logic [10:0] exp_word(input int i);
    int k;
    k = i % N;
    return {k == 0, (k % IW) == IW - 1, k == N - 1, 8'(8'h10 + k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    beats.delete();
    pop_cyc.delete();
    done_cyc.delete();
    first_valid_cyc = -1;
    stall_viol = 0;
    occ_viol   = 0;
    addr_viol  = 0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() >= n) break;
      tick();
    end
    ok = (done_cyc.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; xs.x_ready = 1'b0;
    tick(); tick();
    tests_run++; if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0)      begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (mem_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b expected 0", mem_rd_en); end
    tests_run++; if (mem_addr !== '0)    begin tests_failed++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
    tests_run++; if (xs.x_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", xs.x_valid); end
    tests_run++; if (cur !== '0)         begin tests_failed++; $display("FAIL reset_stream: got %03h expected 000", cur); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int t0; bit ok;
    clear_log();
    xs.x_ready = 1'b1; start = 1'b1; t0 = cyc + 1;
    tick(); start = 1'b0;
    wait_done(1, 100, ok);
    tick(); tick();
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL s1_timeout: got no done expected done"); end
    tests_run++; if (beats.size() != N) begin tests_failed++; $display("FAIL s1_count: got %0d expected %0d", beats.size(), N); end
    for (int i = 0; i < beats.size(); i++) begin
      tests_run++;
      if (beats[i] !== exp_word(i)) begin tests_failed++; $display("FAIL s1_pixel[%0d]: got %03h expected %03h", i, beats[i], exp_word(i)); end
    end
    tests_run++; if (first_valid_cyc != t0 + 2) begin tests_failed++; $display("FAIL s1_latency: got %0d expected %0d", first_valid_cyc - t0, 2); end
    tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("FAIL s1_done_count: got %0d expected 1", done_cyc.size()); end
    if (done_cyc.size() > 0) begin
      tests_run++; if (done_cyc[0] != t0 + N + 2) begin tests_failed++; $display("FAIL s1_done_time: got %0d expected %0d", done_cyc[0] - t0, N + 2); end
    end
    if (pop_cyc.size() == N) begin
      tests_run++; if (pop_cyc[N-1] - pop_cyc[0] != N - 1) begin tests_failed++; $display("FAIL s1_rate: got span %0d expected %0d", pop_cyc[N-1] - pop_cyc[0], N - 1); end
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL s1_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_log();
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      start = (k == 0);
      if (k < 12)      xs.x_ready = k[0];
      else if (k < 17) xs.x_ready = 1'b0;
      else             xs.x_ready = 1'b1;
      tick();
      if (done_cyc.size() >= 1) begin ok = 1'b1; break; end
    end
    start = 1'b0; xs.x_ready = 1'b1;
    tick(); tick();
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL s2_timeout: got no done expected done"); end
    tests_run++; if (beats.size() != N) begin tests_failed++; $display("FAIL s2_count: got %0d expected %0d", beats.size(), N); end
    for (int i = 0; i < beats.size(); i++) begin
      tests_run++;
      if (beats[i] !== exp_word(i)) begin tests_failed++; $display("FAIL s2_pixel[%0d]: got %03h expected %03h", i, beats[i], exp_word(i)); end
    end
    tests_run++; if (stall_viol != 0) begin tests_failed++; $display("FAIL s2_stall_hold: got %0d changes expected 0", stall_viol); end
    tests_run++; if (occ_viol != 0)   begin tests_failed++; $display("FAIL s2_occupancy: got %0d overissues expected 0", occ_viol); end
    tests_run++; if (addr_viol != 0)  begin tests_failed++; $display("FAIL s2_addr: got %0d bad addresses expected 0", addr_viol); end
    tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("FAIL s2_done_count: got %0d expected 1", done_cyc.size()); end
  endtask

  task automatic test_start_ignored();
    clear_log();
    xs.x_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    tests_run++; if (beats.size() != N) begin tests_failed++; $display("FAIL s3_count: got %0d expected %0d", beats.size(), N); end
    tests_run++; if (done_cyc.size() != 1) begin tests_failed++; $display("FAIL s3_done_count: got %0d expected 1", done_cyc.size()); end
    if (beats.size() > 0) begin
      tests_run++; if (beats[beats.size()-1] !== exp_word(N - 1)) begin tests_failed++; $display("FAIL s3_last: got %03h expected %03h", beats[beats.size()-1], exp_word(N - 1)); end
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL s3_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    clear_log();
    xs.x_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (beats.size() >= 6) break;
      tick();
    end
    rst_n = 1'b0; xs.x_ready = 1'b0;
    tick();
    tests_run++; if (beats.size() != 6) begin tests_failed++; $display("FAIL s4_pre_count: got %0d expected 6", beats.size()); end
    tests_run++; if (busy !== 1'b0)       begin tests_failed++; $display("FAIL s4_busy: got %b expected 0", busy); end
    tests_run++; if (mem_rd_en !== 1'b0)  begin tests_failed++; $display("FAIL s4_rd_en: got %b expected 0", mem_rd_en); end
    tests_run++; if (mem_addr !== '0)     begin tests_failed++; $display("FAIL s4_addr: got %0h expected 0", mem_addr); end
    tests_run++; if (xs.x_valid !== 1'b0) begin tests_failed++; $display("FAIL s4_valid: got %b expected 0", xs.x_valid); end
    tests_run++; if (cur !== '0)          begin tests_failed++; $display("FAIL s4_stream: got %03h expected 000", cur); end
    rst_n = 1'b1; xs.x_ready = 1'b1;
    tick(); tick();
    tests_run++; if (done_cyc.size() != 0) begin tests_failed++; $display("FAIL s4_partial_done: got %0d expected 0", done_cyc.size()); end
    clear_log();
    start = 1'b1;
    tick(); start = 1'b0;
    wait_done(1, 100, ok);
    tick(); tick();
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL s4_timeout: got no done expected done"); end
    tests_run++; if (beats.size() != N) begin tests_failed++; $display("FAIL s4_count: got %0d expected %0d", beats.size(), N); end
    for (int i = 0; i < beats.size(); i++) begin
      tests_run++;
      if (beats[i] !== exp_word(i)) begin tests_failed++; $display("FAIL s4_pixel[%0d]: got %03h expected %03h", i, beats[i], exp_word(i)); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sofs;
    clear_log();
    xs.x_ready = 1'b1; start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done_cyc.size() >= 1) begin tick(); break; end
    end
    start = 1'b0;
    wait_done(2, 100, ok);
    tick(); tick();
    sofs = 0;
    foreach (beats[i]) if (beats[i][10]) sofs++;
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL s5_timeout: got %0d done expected 2", done_cyc.size()); end
    tests_run++; if (beats.size() != 2 * N) begin tests_failed++; $display("FAIL s5_count: got %0d expected %0d", beats.size(), 2 * N); end
    for (int i = 0; i < beats.size(); i++) begin
      tests_run++;
      if (beats[i] !== exp_word(i)) begin tests_failed++; $display("FAIL s5_pixel[%0d]: got %03h expected %03h", i, beats[i], exp_word(i)); end
    end
    tests_run++; if (sofs != 2) begin tests_failed++; $display("FAIL s5_sof_count: got %0d expected 2", sofs); end
    tests_run++; if (done_cyc.size() != 2) begin tests_failed++; $display("FAIL s5_done_count: got %0d expected 2", done_cyc.size()); end
    if (done_cyc.size() == 2) begin
      tests_run++; if (done_cyc[1] - done_cyc[0] != N + 3) begin tests_failed++; $display("FAIL s5_gap: got %0d expected %0d", done_cyc[1] - done_cyc[0], N + 3); end
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_log();
    ok = 1'b1;
    for (int f = 0; f < 3; f++) begin
      start = 1'b1;
      xs.x_ready = ($urandom_range(0, 9) < 7);
      tick(); start = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (done_cyc.size() >= f + 1) break;
        xs.x_ready = ($urandom_range(0, 9) < 7);
        tick();
      end
      if (done_cyc.size() < f + 1) ok = 1'b0;
      xs.x_ready = 1'b1;
      tick();
    end
    tick();
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL s6_timeout: got %0d done expected 3", done_cyc.size()); end
    tests_run++; if (beats.size() != 3 * N) begin tests_failed++; $display("FAIL s6_count: got %0d expected %0d", beats.size(), 3 * N); end
    for (int i = 0; i < beats.size(); i++) begin
      tests_run++;
      if (beats[i] !== exp_word(i)) begin tests_failed++; $display("FAIL s6_pixel[%0d]: got %03h expected %03h", i, beats[i], exp_word(i)); end
    end
    tests_run++; if (stall_viol != 0) begin tests_failed++; $display("FAIL s6_stall_hold: got %0d changes expected 0", stall_viol); end
    tests_run++; if (occ_viol != 0)   begin tests_failed++; $display("FAIL s6_occupancy: got %0d overissues expected 0", occ_viol); end
    tests_run++; if (addr_viol != 0)  begin tests_failed++; $display("FAIL s6_addr: got %0d bad addresses expected 0", addr_viol); end
  endtask

  initial begin
    xs.x_ready = 1'b0;
    first_valid_cyc = -1;
    for (int i = 0; i < N; i++) ram[i] = pixel_t'(8'h10 + i);
    test_reset();
    test_stream();
    test_backpressure();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/image_stream_reader.md
Name: image_stream_reader

Overview:
Frame-source block that streams a stored grayscale image out of an on-chip synchronous-read RAM as a raster-order valid/ready pixel stream. It feeds the convolution_filter input port (x_valid/x_ready/x_data) in hardware, in the way the simulation harness does today. It hides the RAM's 1-cycle read latency behind a small FIFO, so it sustains 1 pixel/clk and honours backpressure without dropping or duplicating pixels. It also emits frame/line markers and a done pulse for the downstream control FSM.

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
W, 8, pixel width in bits
ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT) (19), RAM address width
FIFO_DEPTH, 4, output FIFO entries; legal values are >= 3

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle request to stream one frame; ignored while busy
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the last pixel has been handshaked
mem_rd_en  out  1  RAM read strobe
mem_addr  out  ADDR_W  RAM read address, linear raster order
mem_rd_data  in  W  RAM data, valid the cycle after mem_rd_en
x_valid  out  1  pixel valid
x_ready  in  1  downstream ready
x_data  out  W  pixel
x_sof  out  1  qualifies the first pixel of the frame (addr 0)
x_eol  out  1  qualifies the last pixel of each line (col == IMG_WIDTH-1)
x_eof  out  1  qualifies the last pixel of the frame

Behaviour:
- Reset, synchronous on rst_n low: all outputs are 0, FSM goes to IDLE, FIFO count goes to 0, the read counter goes to 0, and any in-flight RAM read is discarded. The same applies mid-frame; no partial done is produced.
- FSM states:
  - IDLE: on start go to ISSUE.
  - ISSUE: issues reads for addresses 0..N-1, where N = IMG_WIDTH*IMG_HEIGHT. After issuing addr N-1, go to DRAIN.
  - DRAIN: when the FIFO is empty and no read is in flight, go to IDLE and pulse done for 1 cycle.
- busy is 1 in ISSUE and DRAIN.
- Read issue rule: mem_rd_en = (state == ISSUE) && (fifo_count + inflight < FIFO_DEPTH). All terms are registered, so there is no combinational path from x_ready to the RAM.
- mem_addr increments by 1 after each issued read.
- inflight: a 1-bit register, set by mem_rd_en and cleared the next cycle.
- Returned data is pushed into the FIFO together with {sof, eol, eof} flags. The flags are computed at issue time from the column/row counters and travel with the read.
- Output side:
  - x_valid = FIFO non-empty. x_data and the flags come from the FIFO head.
  - A pop occurs on x_valid && x_ready.
  - While x_valid && !x_ready, x_data and the flags are held stable and x_valid does not drop.
- Latency: start sampled at edge T0 → mem_rd_en high with mem_addr = 0 from T0. RAM data is valid after T1 and written to the FIFO at T2. x_valid is high from T2, giving a first pixel 2 cycles after start.
- Throughput: with x_ready held high, one pixel per clock continuously. A frame takes N+2 cycles from start to done.
- FIFO push and pop in the same cycle: the count is unchanged. The FIFO never overflows, which the issue rule guarantees; an overflow is an assertion failure.
- Counters: column wraps at IMG_WIDTH-1 and increments row. Row wraps at IMG_HEIGHT-1. Both reset to 0 at start.
- start while busy is ignored. start in the same cycle as done is accepted, giving back-to-back frames.

Decomposition:
- Package img_stream_pkg holds:
  - IMG_WIDTH and IMG_HEIGHT defaults
  - pixel_t (logic [W-1:0])
  - stream_flags_t struct {sof, eol, eof}
  - the FSM state enum {IDLE, ISSUE, DRAIN}
- Sub-module stream_fifo: a synchronous FIFO parameterised by width and depth, with count, empty and full outputs. Its storage word is {stream_flags_t, pixel_t}.

Test Plan:
- Test configuration: IMG_WIDTH=4, IMG_HEIGHT=3, RAM preloaded with mem[i] = 8'h10 + i.
- Scenario 1: start pulse, x_ready=1 → x_valid high 2 cycles after start. Data 10,11,...,1B over 12 consecutive cycles. x_sof only on 10. x_eol on 13, 17, 1B. x_eof only on 1B. done pulses once, 14 cycles after start.
- Scenario 2: start, x_ready toggles 1010… and then is held 0 for 5 cycles mid-line → same 12-value sequence with no drop or duplicate. x_data stable while stalled. mem_rd_en never raises fifo_count + inflight above 4.
- Scenario 3: start asserted again at cycle 5 of a frame → ignored; exactly 12 pixels and one done.
- Scenario 4: rst_n low for 1 cycle after pixel 6 is accepted → all outputs 0 and busy=0 the next cycle. A new start streams from 10 again with x_sof set.
- Scenario 5: start held high through done → second frame begins immediately. 24 pixels total, x_sof twice, done twice.
- Scenario 6: full size 640x480 with a random x_ready (70% high) → 307200 pixels, matching a golden RAM dump in order. Terminate via done.
